// File: rtl/dvs_pkg.sv
// Shared DVS readout constants and the packed event word layout.
package dvs_pkg;

  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_AWIDTH     = 10;
  localparam int FIFO_DEPTH      = (2 ** FIFO_AWIDTH) - 1;

  localparam int EV_X_W   = 8;
  localparam int EV_Y_W   = 8;
  localparam int EV_POL_W = 1;
  localparam int EV_TS_W  = FIFO_DATA_WIDTH - EV_X_W - EV_Y_W - EV_POL_W;

  typedef struct packed {
    logic [EV_X_W-1:0]   x;
    logic [EV_Y_W-1:0]   y;
    logic [EV_POL_W-1:0] polarity;
    logic [EV_TS_W-1:0]  timestamp;
  } event_word_t;

endpackage

// File: rtl/event_fifo_if.sv
// Event FIFO bus: upstream event handshake plus the register-file pop/occupancy side.
interface event_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AWIDTH     = 10
) ();

  logic                  ev_valid;
  logic [DATA_WIDTH-1:0] ev_data;
  logic                  ev_ready;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [AWIDTH-1:0]     fifo_numel;

  modport master (
    output ev_valid, ev_data, fifo_rd_en,
    input  ev_ready, fifo_rdata, fifo_numel
  );

  modport slave (
    input  ev_valid, ev_data, fifo_rd_en,
    output ev_ready, fifo_rdata, fifo_numel
  );

endinterface

// File: rtl/event_fifo_irq.sv
// Hysteresis interrupt: sets at or above the assert level, clears at or below the deassert level.
module event_fifo_irq
  import dvs_pkg::*;
#(
  parameter int AWIDTH = FIFO_AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_n,
  input  logic [AWIDTH-1:0] numel,
  input  logic [AWIDTH-1:0] assert_thresh,
  input  logic [AWIDTH-1:0] deassert_thresh,
  output logic              irq
);

  logic irq_r;

  // Interrupt level register; set wins when the two thresholds overlap
  always_ff @(posedge clk) begin
    if (!rst_n || !clear_n) begin
      irq_r <= 1'b0;
    end else if (assert_thresh == {AWIDTH{1'b0}}) begin
      irq_r <= 1'b0;
    end else if (numel >= assert_thresh) begin
      irq_r <= 1'b1;
    end else if (numel <= deassert_thresh) begin
      irq_r <= 1'b0;
    end
  end

  assign irq = irq_r;

endmodule

// File: rtl/event_fifo.sv
// First-word-fall-through ring buffer for DVS events with hysteresis interrupt.
// Lossy mode (drop events while full, count them) is built when EVENT_FIFO_DROP_EN is defined.
module event_fifo
  import dvs_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int AWIDTH     = FIFO_AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_rst_n,
  event_fifo_if.slave       bus,
  input  logic [AWIDTH-1:0] irq_assert_thresh,
  input  logic [AWIDTH-1:0] irq_deassert_thresh,
  output logic              irq,
  output logic [15:0]       drop_cnt
);

  localparam int                DEPTH   = (2 ** AWIDTH) - 1;
  localparam logic [AWIDTH-1:0] FULL_V  = AWIDTH'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_V  = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] ZERO_V  = {AWIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AWIDTH-1:0]     wr_ptr_r;
  logic [AWIDTH-1:0]     rd_ptr_r;
  logic [AWIDTH-1:0]     numel_r;
  logic                  clear_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  ready_s;
  logic                  push_s;
  logic                  pop_s;
`ifdef EVENT_FIFO_DROP_EN
  logic                  drop_s;
  logic [15:0]           drop_cnt_r;
`endif

  // Pointers wrap at DEPTH, not at 2**AWIDTH, so occupancy always fits in AWIDTH bits
  function automatic logic [AWIDTH-1:0] ptr_next(input logic [AWIDTH-1:0] p);
    return (p == LAST_V) ? ZERO_V : p + AWIDTH'(1);
  endfunction

  // Handshake qualification; nothing moves while either reset is asserted
  always_comb begin
    clear_s = !rst_n || !fifo_rst_n;
    full_s  = (numel_r == FULL_V);
    empty_s = (numel_r == ZERO_V);
`ifdef EVENT_FIFO_DROP_EN
    ready_s = !clear_s;
    drop_s  = bus.ev_valid && ready_s && full_s;
`else
    ready_s = !clear_s && !full_s;
`endif
    push_s  = bus.ev_valid && ready_s && !full_s;
    pop_s   = bus.fifo_rd_en && !empty_s && !clear_s;
  end

  // Storage array, deliberately left uncleared by either reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.ev_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n || !fifo_rst_n) begin
      wr_ptr_r <= ZERO_V;
      rd_ptr_r <= ZERO_V;
      numel_r  <= ZERO_V;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   numel_r <= numel_r + AWIDTH'(1);
        2'b01:   numel_r <= numel_r - AWIDTH'(1);
        default: numel_r <= numel_r;
      endcase
    end
  end

`ifdef EVENT_FIFO_DROP_EN
  // Saturating count of events discarded while full
  always_ff @(posedge clk) begin
    if (!rst_n || !fifo_rst_n) begin
      drop_cnt_r <= 16'h0000;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'h0001;
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  assign drop_cnt = 16'h0000;
`endif

  assign bus.ev_ready   = ready_s;
  assign bus.fifo_rdata = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign bus.fifo_numel = numel_r;

  event_fifo_irq #(
    .AWIDTH(AWIDTH)
  ) u_irq (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear_n         (fifo_rst_n),
    .numel           (numel_r),
    .assert_thresh   (irq_assert_thresh),
    .deassert_thresh (irq_deassert_thresh),
    .irq             (irq)
  );

endmodule
